// File: rtl/preempt_pkg.sv
// preempt_pkg: shared state encoding and default addresses for the preemption switch controller.
package preempt_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_BND, SAVE, REDIR, IN_OS} state_e;
  localparam logic [31:0] USER_BASE_DEF  = 32'd3000;
  localparam logic [31:0] OS_HANDLER_DEF = 32'd100;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the next live process after the current one.
module rr_picker #(
  parameter int NPROC = 4,
  parameter int PIDW  = 2
) (
  input  logic [NPROC-1:0] proc_ativo_i,
  input  logic [PIDW-1:0]  proc_atual_i,
  output logic [PIDW-1:0]  next_pid_o
);
  // Scan farthest-first so the nearest live slot after the current one wins; own slot is last.
  always_comb begin
    next_pid_o = proc_atual_i;
    for (int k = NPROC; k >= 1; k--) begin
      automatic int idx = (int'(proc_atual_i) + k) % NPROC;
      if (proc_ativo_i[idx[PIDW-1:0]]) next_pid_o = idx[PIDW-1:0];
    end
  end
endmodule

// File: rtl/preempt_switch_ctrl.sv
// preempt_switch_ctrl: turns the timer preemption flag into a boundary-safe context switch.
// Optional switch counter on num_trocas enabled by PREEMPT_STATS_EN.
module preempt_switch_ctrl
  import preempt_pkg::*;
#(
  parameter int          NPROC      = 4,
  parameter int          PIDW       = 2,
  parameter logic [31:0] USER_BASE  = USER_BASE_DEF,
  parameter logic [31:0] OS_HANDLER = OS_HANDLER_DEF
) (
  input  logic             clock_auto,
  input  logic             reset,
  input  logic             timer,
  input  logic [31:0]      pc_atual,
  input  logic             instr_done,
  input  logic [NPROC-1:0] proc_ativo,
  input  logic             os_ack,
  output logic             irq,
  output logic             pc_redirect_v,
  output logic [31:0]      pc_redirect,
  output logic             timer_clear,
  output logic [31:0]      epc,
  output logic [PIDW-1:0]  proc_atual,
  output logic [PIDW-1:0]  proc_prox,
  output logic [31:0]      num_trocas
);
  state_e            state_q, state_d;
  logic [31:0]       epc_q, epc_d;
  logic [PIDW-1:0]   cur_q, cur_d, prox_q, prox_d, pick;

  rr_picker #(.NPROC(NPROC), .PIDW(PIDW)) u_rr (
    .proc_ativo_i(proc_ativo),
    .proc_atual_i(cur_q),
    .next_pid_o  (pick)
  );

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cur_d   = cur_q;
    prox_d  = prox_q;
    case (state_q)
      IDLE:     if (timer && pc_atual >= USER_BASE) state_d = WAIT_BND;
      WAIT_BND: if (!timer) state_d = IDLE;
                else if (instr_done) begin
                  epc_d   = pc_atual;
                  state_d = SAVE;
                end
      SAVE: begin
        prox_d  = pick;
        state_d = REDIR;
      end
      REDIR:    state_d = IN_OS;
      IN_OS:    if (os_ack) begin
                  cur_d   = prox_q;
                  state_d = IDLE;
                end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_auto or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cur_q   <= '0;
      prox_q  <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cur_q   <= cur_d;
      prox_q  <= prox_d;
    end
  end

  assign irq           = state_q != IDLE;
  assign pc_redirect_v = state_q == REDIR;
  assign timer_clear   = pc_redirect_v;
  assign pc_redirect   = pc_redirect_v ? OS_HANDLER : '0;
  assign epc           = epc_q;
  assign proc_atual    = cur_q;
  assign proc_prox     = prox_q;

`ifdef PREEMPT_STATS_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clock_auto or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (state_q == IN_OS && os_ack && cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
  end
  assign num_trocas = cnt_q;
`else
  assign num_trocas = '0;
`endif
endmodule

// File: tb/tb_preempt_switch_ctrl.sv
// tb_preempt_switch_ctrl: directed self-checking bench for preempt_switch_ctrl.
module tb_preempt_switch_ctrl;
  logic        clock_auto = 0, reset = 1, timer = 0, instr_done = 0, os_ack = 0;
  logic [31:0] pc_atual = 0;
  logic [3:0]  proc_ativo = 0;
  logic        irq, pc_redirect_v, timer_clear;
  logic [31:0] pc_redirect, epc, num_trocas;
  logic [1:0]  proc_atual, proc_prox;
  int checks = 0, failures = 0, nsw = 0;

  preempt_switch_ctrl dut (
    .clock_auto(clock_auto), .reset(reset), .timer(timer), .pc_atual(pc_atual),
    .instr_done(instr_done), .proc_ativo(proc_ativo), .os_ack(os_ack),
    .irq(irq), .pc_redirect_v(pc_redirect_v), .pc_redirect(pc_redirect),
    .timer_clear(timer_clear), .epc(epc), .proc_atual(proc_atual),
    .proc_prox(proc_prox), .num_trocas(num_trocas)
  );

  always #5 clock_auto = ~clock_auto;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_auto);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef PREEMPT_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic full_switch(input logic [31:0] pc, input logic [3:0] act, input int dly,
                             input logic [1:0] exp_prox, input string tag);
    pc_atual = pc; proc_ativo = act; timer = 1;
    tick();
    check({tag, " irq_wait"}, irq, 1);
    repeat (dly - 1) tick();
    check({tag, " no_redir_wait"}, pc_redirect_v, 0);
    instr_done = 1;
    tick();
    instr_done = 0;
    check({tag, " epc"}, epc, pc);
    check({tag, " no_redir_save"}, pc_redirect_v, 0);
    tick();
    check({tag, " redir_v"}, pc_redirect_v, 1);
    check({tag, " timer_clear"}, timer_clear, 1);
    check({tag, " redir_addr"}, pc_redirect, 100);
    check({tag, " prox"}, proc_prox, exp_prox);
    tick();
    tick();
    check({tag, " in_os_irq"}, irq, 1);
    check({tag, " in_os_no_redir"}, pc_redirect_v, 0);
    os_ack = 1;
    tick();
    os_ack = 0; timer = 0;
    nsw++;
    check({tag, " atual"}, proc_atual, exp_prox);
    check({tag, " idle_irq"}, irq, 0);
    check({tag, " cnt"}, num_trocas, exp_cnt(nsw));
  endtask

  initial begin
    #12 reset = 0;
    #1;
    check("rst irq", irq, 0);
    check("rst redir_v", pc_redirect_v, 0);
    check("rst redir", pc_redirect, 0);
    check("rst clear", timer_clear, 0);
    check("rst epc", epc, 0);
    check("rst atual", proc_atual, 0);
    check("rst prox", proc_prox, 0);
    check("rst cnt", num_trocas, 0);
    full_switch(32'd3500, 4'b0010, 1, 2'd1, "pre");
    full_switch(32'd3200, 4'b0110, 3, 2'd2, "t1");
    full_switch(32'd4000, 4'b0100, 1, 2'd2, "t3self");
    check("t6 cnt3", num_trocas, exp_cnt(3));
    full_switch(32'd4100, 4'b0000, 2, 2'd2, "t3none");
    full_switch(32'd5000, 4'b1000, 1, 2'd3, "t2pre");
    full_switch(32'd3000, 4'b1001, 1, 2'd0, "t2wrap");
    pc_atual = 2900; timer = 1;
    tick(); tick();
    check("t4 os_pc irq", irq, 0);
    pc_atual = 3100;
    tick();
    check("t4 user irq", irq, 1);
    timer = 0;
    tick();
    check("t4 abort irq", irq, 0);
    tick();
    check("t4 abort redir", pc_redirect_v, 0);
    check("t4 abort epc", epc, 3000);
    timer = 1;
    tick();
    check("t4b wait irq", irq, 1);
    timer = 0; instr_done = 1;
    tick();
    instr_done = 0;
    check("t4b prio irq", irq, 0);
    check("t4b prio epc", epc, 3000);
    timer = 1; pc_atual = 3300;
    tick();
    check("t5 wait irq", irq, 1);
    #2 reset = 1;
    #1;
    check("t5 rst irq", irq, 0);
    check("t5 rst epc", epc, 0);
    check("t5 rst prox", proc_prox, 0);
    check("t5 rst cnt", num_trocas, 0);
    timer = 0;
    tick();
    reset = 0;
    tick();
    check("t5 post irq", irq, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
